// File: rtl/gb_vram_arbiter_if.sv
// VRAM arbiter bus bundle: PPU, DMA and CPU requesters plus the VRAM macro side.
// slave = arbiter view, master = requesters/VRAM view.
interface gb_vram_arbiter_if #(
   parameter int ADR_W = 13
);
   logic             ppu_active;
   logic             ppu_req;
   logic [ADR_W-1:0] ppu_adr;
   logic             ppu_ack;
   logic [7:0]       ppu_data;
   logic             dma_req;
   logic [ADR_W-1:0] dma_adr;
   logic             dma_ack;
   logic [7:0]       dma_data;
   logic             cpu_req;
   logic             cpu_we;
   logic [ADR_W-1:0] cpu_adr;
   logic [7:0]       cpu_din;
   logic             cpu_ack;
   logic [7:0]       cpu_dout;
   logic [ADR_W-1:0] vram_adr;
   logic [ADR_W-1:0] vram_vadr;
   logic             vram_ppu_active;
   logic [7:0]       vram_din;
   logic             vram_read;
   logic             vram_write;
   logic [7:0]       vram_dout;

   modport slave (
      input  ppu_active, ppu_req, ppu_adr,
      input  dma_req, dma_adr,
      input  cpu_req, cpu_we, cpu_adr, cpu_din,
      input  vram_dout,
      output ppu_ack, ppu_data, dma_ack, dma_data,
      output cpu_ack, cpu_dout,
      output vram_adr, vram_vadr, vram_ppu_active,
      output vram_din, vram_read, vram_write
   );

   modport master (
      output ppu_active, ppu_req, ppu_adr,
      output dma_req, dma_adr,
      output cpu_req, cpu_we, cpu_adr, cpu_din,
      output vram_dout,
      input  ppu_ack, ppu_data, dma_ack, dma_data,
      input  cpu_ack, cpu_dout,
      input  vram_adr, vram_vadr, vram_ppu_active,
      input  vram_din, vram_read, vram_write
   );
endinterface

// File: rtl/gb_vram_arbiter.sv
// Single-port VRAM sequencer: PPU > DMA > CPU, 4-cycle accesses,
// CPU lockout while the PPU renders (mode 3).
module gb_vram_arbiter #(
   parameter logic [7:0] BLOCKED_DATA = 8'hFF,
   parameter int         ADR_W        = 13
) (
   input logic clk,
   input logic reset,
   gb_vram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, CAPTURE} state_t;
   typedef enum logic [1:0] {G_NONE, G_PPU, G_DMA, G_CPU} grant_t;

   state_t           state;
   grant_t           grant;
   logic             we_q;
   logic             blk_q;
   logic             ppu_ack_q;
   logic             dma_ack_q;
   logic             cpu_ack_q;
   logic [7:0]       ppu_q;
   logic [7:0]       dma_q;
   logic [7:0]       cpu_q;
   logic [ADR_W-1:0] adr_q;
   logic [ADR_W-1:0] vadr_q;
   logic             vppu_q;
   logic [7:0]       din_q;
   logic             rd_q;
   logic             wr_q;
   logic [7:0]       rd_val;

   assign rd_val = blk_q ? BLOCKED_DATA : bus.vram_dout;

   // RAM data only arrives in CAPTURE, so the ack cycle bypasses the holding regs
   assign bus.ppu_ack  = ppu_ack_q;
   assign bus.dma_ack  = dma_ack_q;
   assign bus.cpu_ack  = cpu_ack_q;
   assign bus.ppu_data = ppu_ack_q ? rd_val : ppu_q;
   assign bus.dma_data = dma_ack_q ? rd_val : dma_q;
   assign bus.cpu_dout = (cpu_ack_q && !we_q) ? rd_val : cpu_q;

   assign bus.vram_adr        = adr_q;
   assign bus.vram_vadr       = vadr_q;
   assign bus.vram_ppu_active = vppu_q;
   assign bus.vram_din        = din_q;
   assign bus.vram_read       = rd_q;
   assign bus.vram_write      = wr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= G_NONE;
         we_q      <= 1'b0;
         blk_q     <= 1'b0;
         ppu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
         cpu_ack_q <= 1'b0;
         ppu_q     <= 8'h00;
         dma_q     <= 8'h00;
         cpu_q     <= 8'h00;
         adr_q     <= {ADR_W{1'b0}};
         vadr_q    <= {ADR_W{1'b0}};
         vppu_q    <= 1'b0;
         din_q     <= 8'h00;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
      end else begin
         ppu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
         cpu_ack_q <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.ppu_req) begin
                  grant  <= G_PPU;
                  vadr_q <= bus.ppu_adr;
                  vppu_q <= 1'b1;
                  we_q   <= 1'b0;
                  blk_q  <= 1'b0;
                  state  <= SETUP;
               end else if (bus.dma_req && !bus.ppu_active) begin
                  grant <= G_DMA;
                  adr_q <= bus.dma_adr;
                  we_q  <= 1'b0;
                  blk_q <= 1'b0;
                  state <= SETUP;
               end else if (bus.cpu_req) begin
                  // lockout is decided here and frozen for the whole access
                  grant <= G_CPU;
                  adr_q <= bus.cpu_adr;
                  din_q <= bus.cpu_din;
                  we_q  <= bus.cpu_we;
                  blk_q <= bus.ppu_active;
                  state <= SETUP;
               end
            end
            SETUP: begin
               rd_q  <= (grant != G_CPU) || (!we_q && !blk_q);
               wr_q  <= (grant == G_CPU) && we_q && !blk_q;
               state <= STROBE;
            end
            STROBE: begin
               ppu_ack_q <= (grant == G_PPU);
               dma_ack_q <= (grant == G_DMA);
               cpu_ack_q <= (grant == G_CPU);
               state     <= CAPTURE;
            end
            CAPTURE: begin
               unique case (grant)
                  G_PPU:   ppu_q <= rd_val;
                  G_DMA:   dma_q <= rd_val;
                  G_CPU:   if (!we_q) cpu_q <= rd_val;
                  default: ;
               endcase
               vppu_q <= 1'b0;
               grant  <= G_NONE;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
